// File: rtl/prbs_generator.sv
// Free-running Fibonacci-LFSR PRBS source (ITU-style polynomials, order 7/9/15/23/31).
// Define PRBS_ERR_INJECT_EN to add the err_inject port for single-bit error insertion.
module prbs_generator #(
  parameter int unsigned              PRBS_ORDER = 7,
  parameter logic [PRBS_ORDER-1:0]    SEED       = '1
) (
  input  logic clk,
  input  logic reset,
`ifdef PRBS_ERR_INJECT_EN
  input  logic err_inject,
`endif
  output logic prbs_output
);

  localparam int unsigned N = PRBS_ORDER;

  function automatic int unsigned tap_of(input int unsigned order);
    case (order)
      7:       return 6;
      9:       return 5;
      15:      return 14;
      23:      return 18;
      31:      return 28;
      default: return 0;
    endcase
  endfunction

  localparam int unsigned TAP = tap_of(N);

  // A zero seed would lock the LFSR up, so it is swapped for all ones.
  localparam logic [N-1:0] LOAD_VAL = (SEED == '0) ? {N{1'b1}} : SEED;

  if (TAP == 0) begin : g_bad_order
    $fatal(1, "prbs_generator: PRBS_ORDER must be 7, 9, 15, 23 or 31");
  end

  logic [N-1:0] r_state;
  logic         w_fb;
  logic         w_lockup;

  assign w_fb     = r_state[N-1] ^ r_state[TAP-1];
  assign w_lockup = (r_state == '0);

  // LFSR state: shift left, feedback enters at bit 0, output taken from the MSB.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= LOAD_VAL;
    end else if (w_lockup) begin
      r_state <= LOAD_VAL;
    end else begin
      r_state <= {r_state[N-2:0], w_fb};
    end
  end

`ifdef PRBS_ERR_INJECT_EN
  logic r_flip;

  // Inversion flag lives outside the LFSR so the sequence recovers on the next bit.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_flip <= 1'b0;
    end else begin
      r_flip <= err_inject;
    end
  end

  assign prbs_output = r_state[N-1] ^ r_flip;
`else
  assign prbs_output = r_state[N-1];
`endif

endmodule

// File: tb/tb_prbs_generator.sv
// Directed bench for prbs_generator: orders 7/9/15/23/31, zero seed, resets and
// (with PRBS_ERR_INJECT_EN) single-cycle error injection.
module tb_prbs_generator;

  localparam int unsigned CAP = 32767 + 64;
  localparam int unsigned D7  = 0;
  localparam int unsigned D9  = 1;
  localparam int unsigned D15 = 2;
  localparam int unsigned D23 = 3;
  localparam int unsigned D31 = 4;
  localparam int unsigned DZ  = 5;

  logic clk;
  logic reset;
  logic o7, o9, o15, o23, o31, oz;
`ifdef PRBS_ERR_INJECT_EN
  logic inj;
`endif

  int unsigned vectors     = 0;
  int unsigned miscompares = 0;

  logic cap  [0:5][0:CAP-1];
  logic refb [0:CAP-1];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  prbs_generator #(.PRBS_ORDER(7)) u_p7 (
    .clk(clk), .reset(reset),
`ifdef PRBS_ERR_INJECT_EN
    .err_inject(inj),
`endif
    .prbs_output(o7));

  prbs_generator #(.PRBS_ORDER(9)) u_p9 (
    .clk(clk), .reset(reset),
`ifdef PRBS_ERR_INJECT_EN
    .err_inject(1'b0),
`endif
    .prbs_output(o9));

  prbs_generator #(.PRBS_ORDER(15)) u_p15 (
    .clk(clk), .reset(reset),
`ifdef PRBS_ERR_INJECT_EN
    .err_inject(1'b0),
`endif
    .prbs_output(o15));

  prbs_generator #(.PRBS_ORDER(23)) u_p23 (
    .clk(clk), .reset(reset),
`ifdef PRBS_ERR_INJECT_EN
    .err_inject(1'b0),
`endif
    .prbs_output(o23));

  prbs_generator #(.PRBS_ORDER(31)) u_p31 (
    .clk(clk), .reset(reset),
`ifdef PRBS_ERR_INJECT_EN
    .err_inject(1'b0),
`endif
    .prbs_output(o31));

  prbs_generator #(.PRBS_ORDER(7), .SEED(7'd0)) u_pz (
    .clk(clk), .reset(reset),
`ifdef PRBS_ERR_INJECT_EN
    .err_inject(1'b0),
`endif
    .prbs_output(oz));

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic sample(input int unsigned k);
    cap[D7][k]  = o7;
    cap[D9][k]  = o9;
    cap[D15][k] = o15;
    cap[D23][k] = o23;
    cap[D31][k] = o31;
    cap[DZ][k]  = oz;
  endtask

  // Output-sequence recurrence b[n+N] = b[n] ^ b[n+N-T], all-ones start.
  task automatic build_ref(input int unsigned n, input int unsigned t);
    for (int unsigned i = 0; i < n; i++) refb[i] = 1'b1;
    for (int unsigned i = 0; i + n < CAP; i++) refb[i+n] = refb[i] ^ refb[i+n-t];
  endtask

  function automatic int unsigned mism(input int unsigned d, input int unsigned len);
    int unsigned c = 0;
    for (int unsigned k = 0; k < len; k++) if (cap[d][k] !== refb[k]) c++;
    return c;
  endfunction

  function automatic int unsigned ones(input int unsigned d, input int unsigned from,
                                       input int unsigned len);
    int unsigned c = 0;
    for (int unsigned k = from; k < from + len; k++) if (cap[d][k] === 1'b1) c++;
    return c;
  endfunction

  function automatic logic periodic(input int unsigned d, input int unsigned p,
                                    input int unsigned len);
    for (int unsigned k = 0; k < len; k++) if (cap[d][k] !== cap[d][k+p]) return 1'b0;
    return 1'b1;
  endfunction

  // Number of proper divisors of p under which the captured stream repeats.
  function automatic int unsigned shorter(input int unsigned d, input int unsigned p);
    int unsigned c = 0;
    for (int unsigned q = 1; q < p; q++)
      if ((p % q) == 0 && periodic(d, q, CAP - q)) c++;
    return c;
  endfunction

  function automatic logic [13:0] first14(input int unsigned d);
    logic [13:0] v;
    for (int unsigned k = 0; k < 14; k++) v[13-k] = cap[d][k];
    return v;
  endfunction

  initial begin
    logic [13:0] exp14;
    exp14 = 14'b11111110000001;
    reset = 1'b1;
`ifdef PRBS_ERR_INJECT_EN
    inj = 1'b0;
`endif

    // Reset held two cycles: output parked at the seed MSB.
    @(negedge clk);
    check("rst_hold1_p7", 64'(o7), 64'd1);
    @(negedge clk);
    check("rst_hold2_p7",  64'(o7),  64'd1);
    check("rst_p9",        64'(o9),  64'd1);
    check("rst_p15",       64'(o15), 64'd1);
    check("rst_p23",       64'(o23), 64'd1);
    check("rst_p31",       64'(o31), 64'd1);
    check("rst_zero_seed", 64'(oz),  64'd1);
    reset = 1'b0;

    for (int unsigned k = 0; k < CAP; k++) begin
      sample(k);
      @(negedge clk);
    end

    build_ref(7, 6);
    check("p7_first14",      64'(first14(D7)),         64'(exp14));
    check("p7_bit127",       64'(cap[D7][127]),        64'd1);
    check("p7_model",        64'(mism(D7, 254)),       64'd0);
    check("p7_period127",    64'(periodic(D7, 127, 127)), 64'd1);
    check("p7_ones_per0",    64'(ones(D7, 0, 127)),    64'd64);
    check("p7_ones_per1",    64'(ones(D7, 127, 127)),  64'd64);
    check("p7_no_shorter",   64'(shorter(D7, 127)),    64'd0);
    check("zseed_model",     64'(mism(DZ, CAP)),       64'd0);
    check("zseed_ones",      64'(ones(DZ, 0, 127)),    64'd64);

    build_ref(9, 5);
    check("p9_model",        64'(mism(D9, CAP)),       64'd0);
    check("p9_period511",    64'(periodic(D9, 511, 511)), 64'd1);
    check("p9_ones",         64'(ones(D9, 0, 511)),    64'd256);
    check("p9_no_shorter",   64'(shorter(D9, 511)),    64'd0);

    build_ref(15, 14);
    check("p15_model",       64'(mism(D15, CAP)),      64'd0);
    check("p15_period",      64'(periodic(D15, 32767, 64)), 64'd1);
    check("p15_ones",        64'(ones(D15, 0, 32767)), 64'd16384);
    check("p15_no_shorter",  64'(shorter(D15, 32767)), 64'd0);

    build_ref(23, 18);
    check("p23_model",       64'(mism(D23, CAP)),      64'd0);
    build_ref(31, 28);
    check("p31_model",       64'(mism(D31, CAP)),      64'd0);

    // Single-cycle reset 50 cycles into a running sequence.
    repeat (50) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("midrst_out", 64'(o7), 64'd1);
    reset = 1'b0;
    for (int unsigned k = 0; k < 300; k++) begin
      sample(k);
      @(negedge clk);
    end
    build_ref(7, 6);
    check("midrst_first14", 64'(first14(D7)),   64'(exp14));
    check("midrst_model",   64'(mism(D7, 300)), 64'd0);

`ifdef PRBS_ERR_INJECT_EN
    // err_inject pulse sampled by the edge that produces bit 20.
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    for (int unsigned k = 0; k < 100; k++) begin
      sample(k);
      if (k == 19) inj = 1'b1;
      if (k == 20) inj = 1'b0;
      @(negedge clk);
    end
    check("inj_one_bit",  64'(mism(D7, 100)),  64'd1);
    check("inj_bit20",    64'(cap[D7][20]),    64'(~refb[20]));
    check("inj_bit21",    64'(cap[D7][21]),    64'(refb[21]));
    check("inj_p9_clean", 64'(cap[D9][20] === cap[D9][20]), 64'd1);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/prbs_generator.md
# prbs_generator

Free-running pseudo-random binary sequence (PRBS) source for link, serializer and BER test paths. A Fibonacci LFSR with a compile-time-selectable ITU-style polynomial emits one bit per clock on `prbs_output`. It has no handshake and sits at the head of a test datapath, feeding a serializer or a checker directly.

## Interface

Parameters:
- `PRBS_ORDER`, default 7: LFSR length. Legal values are 7, 9, 15, 23 and 31. Any other value shall fail elaboration.
- `SEED`, default all ones (`PRBS_ORDER` bits): state loaded on reset. An all-zero `SEED` is replaced by all ones.

Ports:
- `clk`, input, 1: single clock. Reset is synchronous and active-high.
- `reset`, input, 1: synchronous, active-high.
- `prbs_output`, output, 1: serial PRBS bit, registered.
- `err_inject`, input, 1: present only with `PRBS_ERR_INJECT_EN`. See Configuration.

## Operation

- State `s[N-1:0]`, where N = `PRBS_ORDER`.
- Feedback `fb = s[N-1] ^ s[T-1]`. Tap T per order:
  - 7 → x^7+x^6+1, T=6
  - 9 → x^9+x^5+1, T=5
  - 15 → x^15+x^14+1, T=14
  - 23 → x^23+x^18+1, T=18
  - 31 → x^31+x^28+1, T=28
- Each non-reset edge: `s <= {s[N-2:0], fb}`.
- `prbs_output = s[N-1]` (XORed with the inject flag when the macro is enabled). No combinational path from inputs.
- Sequence period is 2^N−1 bits. Each period contains 2^(N−1) ones and 2^(N−1)−1 zeros.
- Lockup guard: if `s` is ever all zeros, the next edge loads `SEED` instead of shifting. This is unreachable in normal operation.
- No enable. The generator advances on every clock edge while `reset` is low.

## Timing

- Reset: on an edge with `reset`=1, `s <= SEED`.
  - `prbs_output` reset value = `SEED[N-1]`, which is 1 for the default seed.
  - Inject flag is cleared.
  - Reset takes priority over everything, including mid-sequence assertion.
- First edge with `reset`=0 produces the second sequence bit. The seed MSB is output 0.
- Latency is one bit per cycle, and the sequence is continuous.
- Reset held for multiple cycles keeps the output at `SEED[N-1]` with no advance.
- Re-asserting reset restarts the sequence from bit 0 exactly.
- The 31-bit order must meet timing. The feedback path is a single XOR2.

## Configuration

Macro: `PRBS_ERR_INJECT_EN`.

Defined:
- Adds input `err_inject`.
- Register `flip_q <= err_inject` on every non-reset edge. `flip_q` resets to 0.
- `prbs_output = s[N-1] ^ flip_q`.
- A one-cycle `err_inject` pulse sampled at edge k inverts exactly the output bit visible after edge k.
- LFSR state is unaffected, so the sequence resumes error-free on the next bit.

Not defined:
- No `err_inject` port and no `flip_q` register.
- `prbs_output = s[N-1]`.

## Test plan

- **Default PRBS7 after reset:** hold `reset` 2 cycles, then release. `prbs_output` reads 1 during reset. The first 14 bits from reset are `11111110000001`. Bit 127 equals bit 0.
- **Period and balance, PRBS7:** run 254 cycles. The sequence repeats with period exactly 127, with 64 ones and 63 zeros per period. No shorter period occurs.
- **Order sweep:** set `PRBS_ORDER` to 9, then 15. Periods are 511 and 32767. Output matches a reference LFSR model with the listed taps bit for bit.
- **Mid-sequence reset:** assert `reset` for 1 cycle at cycle 50. The output restarts at `1111111…` on the following edges, identical to the power-up sequence.
- **Zero seed:** set `SEED`=0 with order 7. Behaviour is identical to the all-ones seed, and the output is never stuck at 0.
- **Error inject (`PRBS_ERR_INJECT_EN`):** pulse `err_inject` for 1 cycle at cycle 20. Exactly one output bit is inverted versus the reference model, and all later bits match.
